// File: rtl/l1_axi_bridge.sv
// Single-outstanding bridge from the L1 arbiter request/return bundles to an AXI4 master port.
// One request is accepted in IDLE, carried to completion on AXI, and read beats are returned as they arrive.
module l1_axi_bridge #(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter logic [5:0]  AXI_ID             = 6'd0
) (
    input  logic                              clk,
    input  logic                              rst_n,

    input  logic [31:0]                       l1_request_addr,
    input  logic [31:0]                       l1_request_data,
    input  logic                              l1_request_rnw,
    input  logic [3:0]                        l1_request_be,
    input  logic [4:0]                        l1_request_size,
    input  logic                              l1_request_is_amo,
    input  logic [4:0]                        l1_request_amo,
    input  logic                              l1_request_request,
    output logic                              l1_request_ack,

    output logic [31:0]                       l1_return_data,
    output logic                              l1_return_data_valid,
    output logic [31:0]                       l1_return_inv_addr,
    output logic                              l1_return_inv_valid,
    input  logic                              l1_return_inv_ack,

    output logic [5:0]                        m_axi_awid,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [7:0]                        m_axi_awlen,
    output logic [2:0]                        m_axi_awsize,
    output logic [1:0]                        m_axi_awburst,
    output logic                              m_axi_awlock,
    output logic [3:0]                        m_axi_awcache,
    output logic [2:0]                        m_axi_awprot,
    output logic [3:0]                        m_axi_awqos,
    output logic                              m_axi_awvalid,
    input  logic                              m_axi_awready,

    output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                              m_axi_wlast,
    output logic                              m_axi_wvalid,
    input  logic                              m_axi_wready,

    input  logic [5:0]                        m_axi_bid,
    input  logic [1:0]                        m_axi_bresp,
    input  logic                              m_axi_bvalid,
    output logic                              m_axi_bready,

    output logic [5:0]                        m_axi_arid,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [7:0]                        m_axi_arlen,
    output logic [2:0]                        m_axi_arsize,
    output logic [1:0]                        m_axi_arburst,
    output logic                              m_axi_arlock,
    output logic [3:0]                        m_axi_arcache,
    output logic [2:0]                        m_axi_arprot,
    output logic [3:0]                        m_axi_arqos,
    output logic                              m_axi_arvalid,
    input  logic                              m_axi_arready,

    input  logic [5:0]                        m_axi_rid,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                        m_axi_rresp,
    input  logic                              m_axi_rlast,
    input  logic                              m_axi_rvalid,
    output logic                              m_axi_rready,

    output logic                              bus_error
);

    typedef enum logic [2:0] {
        IDLE,
        AR,
        R,
        AWW,
        B
    } state_t;

    state_t      state, state_nxt;

    logic [29:0] addr_q;
    logic [31:0] data_q;
    logic [3:0]  be_q;
    logic [4:0]  size_q;
    logic [4:0]  beat_cnt;
    logic        aw_done, w_done;
    logic [31:0] ret_data;
    logic        ret_valid;
    logic        err_q;

    logic        ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic        aw_all, w_all;
    logic        beat_err;

    // Request-side fields the bridge never consumes.
    logic        unused_ok;
    assign unused_ok = &{1'b0, l1_request_amo, l1_return_inv_ack, l1_request_addr[1:0],
                         m_axi_bid, m_axi_rid};

    // Valid/ready controls are pure state decodes, so no AXI input reaches an AXI output.
    assign m_axi_arvalid = (state == AR);
    assign m_axi_rready  = (state == R);
    assign m_axi_bready  = (state == B);
    assign m_axi_awvalid = (state == AWW) && !aw_done;
    assign m_axi_wvalid  = (state == AWW) && !w_done;
    assign m_axi_wlast   = m_axi_wvalid;

    assign ar_hs  = m_axi_arvalid && m_axi_arready;
    assign r_hs   = m_axi_rvalid  && m_axi_rready;
    assign aw_hs  = m_axi_awvalid && m_axi_awready;
    assign w_hs   = m_axi_wvalid  && m_axi_wready;
    assign b_hs   = m_axi_bvalid  && m_axi_bready;
    assign aw_all = aw_done || aw_hs;
    assign w_all  = w_done  || w_hs;

    assign beat_err = (m_axi_rresp != 2'b00)
                   || ( m_axi_rlast && (beat_cnt != size_q))
                   || (!m_axi_rlast && (beat_cnt == size_q));

    assign m_axi_arid    = AXI_ID;
    assign m_axi_araddr  = C_M_AXI_ADDR_WIDTH'({addr_q, 2'b00});
    assign m_axi_arlen   = {3'b000, size_q};
    assign m_axi_arsize  = 3'b010;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arqos   = 4'b0000;

    assign m_axi_awid    = AXI_ID;
    assign m_axi_awaddr  = C_M_AXI_ADDR_WIDTH'({addr_q, 2'b00});
    assign m_axi_awlen   = 8'd0;
    assign m_axi_awsize  = 3'b010;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'b0011;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awqos   = 4'b0000;

    assign m_axi_wdata   = C_M_AXI_DATA_WIDTH'(data_q);
    assign m_axi_wstrb   = (C_M_AXI_DATA_WIDTH/8)'(be_q);

    assign l1_return_data       = ret_data;
    assign l1_return_data_valid = ret_valid;
    assign l1_return_inv_addr   = '0;
    assign l1_return_inv_valid  = 1'b0;
    assign bus_error            = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        l1_request_ack = 1'b0;
        case (state)
            IDLE: begin
                if (l1_request_request) begin
                    l1_request_ack = 1'b1;
                    if (l1_request_is_amo) begin
                        state_nxt = IDLE;
                    end else if (l1_request_rnw) begin
                        state_nxt = AR;
                    end else begin
                        state_nxt = AWW;
                    end
                end
            end
            AR: begin
                if (m_axi_arready) begin
                    state_nxt = R;
                end
            end
            R: begin
                if (m_axi_rvalid && m_axi_rlast) begin
                    state_nxt = IDLE;
                end
            end
            AWW: begin
                if (aw_all && w_all) begin
                    state_nxt = B;
                end
            end
            B: begin
                if (m_axi_bvalid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            data_q    <= '0;
            be_q      <= '0;
            size_q    <= '0;
            beat_cnt  <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            ret_data  <= '0;
            ret_valid <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            ret_valid <= 1'b0;

            if (l1_request_ack) begin
                addr_q  <= l1_request_addr[31:2];
                data_q  <= l1_request_data;
                be_q    <= l1_request_be;
                size_q  <= l1_request_size;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                // Atomics are unsupported: answer at once with zero data and flag the error.
                if (l1_request_is_amo) begin
                    ret_data  <= '0;
                    ret_valid <= 1'b1;
                    err_q     <= 1'b1;
                end
            end

            if (ar_hs) begin
                beat_cnt <= '0;
            end

            if (r_hs) begin
                ret_data  <= m_axi_rdata[31:0];
                ret_valid <= 1'b1;
                beat_cnt  <= beat_cnt + 5'd1;
                if (beat_err) begin
                    err_q <= 1'b1;
                end
            end

            if (aw_hs) begin
                aw_done <= 1'b1;
            end
            if (w_hs) begin
                w_done <= 1'b1;
            end

            if (b_hs && (m_axi_bresp != 2'b00)) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_l1_axi_bridge.sv
// Bench for l1_axi_bridge: directed scenarios plus randomized traffic against a transaction-level model
// that predicts returned beats (value and cycle) and the sticky error flag.
module tb_l1_axi_bridge;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [31:0] req_addr, req_data;
    logic        req_rnw, req_is_amo, req_request, req_ack;
    logic [3:0]  req_be;
    logic [4:0]  req_size, req_amo;
    logic [31:0] ret_data, inv_addr;
    logic        ret_valid, inv_valid, inv_ack;

    logic [5:0]  awid, arid, bid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize, awprot, arprot;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awlock, arlock;
    logic [3:0]  awcache, arcache, awqos, arqos, wstrb;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        bus_error;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          model_err = 0;
    logic [31:0] exp_d[$];
    int          exp_c[$];
    logic [31:0] obs_d[$];
    int          obs_c[$];

    l1_axi_bridge #(
        .C_M_AXI_ADDR_WIDTH(32),
        .C_M_AXI_DATA_WIDTH(32),
        .AXI_ID(6'd0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .l1_request_addr(req_addr), .l1_request_data(req_data), .l1_request_rnw(req_rnw),
        .l1_request_be(req_be), .l1_request_size(req_size), .l1_request_is_amo(req_is_amo),
        .l1_request_amo(req_amo), .l1_request_request(req_request), .l1_request_ack(req_ack),
        .l1_return_data(ret_data), .l1_return_data_valid(ret_valid), .l1_return_inv_addr(inv_addr),
        .l1_return_inv_valid(inv_valid), .l1_return_inv_ack(inv_ack),
        .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
        .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache), .m_axi_awprot(awprot),
        .m_axi_awqos(awqos), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid),
        .m_axi_wready(wready),
        .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
        .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache), .m_axi_arprot(arprot),
        .m_axi_arqos(arqos), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready),
        .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ret_valid === 1'b1) begin
            obs_d.push_back(ret_data);
            obs_c.push_back(cyc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=%0d exp=finished", cyc);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic reset_checks();
        check("rst_arvalid", arvalid, 0);
        check("rst_awvalid", awvalid, 0);
        check("rst_wvalid", wvalid, 0);
        check("rst_rready", rready, 0);
        check("rst_bready", bready, 0);
        check("rst_wlast", wlast, 0);
        check("rst_data", ret_data, 0);
        check("rst_data_valid", ret_valid, 0);
        check("rst_bus_error", bus_error, 0);
        check("rst_ack", req_ack, 0);
        check("inv_valid", inv_valid, 0);
        check("inv_addr", inv_addr, 0);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1 reset_checks();
        model_err = 0;
        @(negedge clk);
        check("rst_hold_valid", ret_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Idle two cycles, then compare returned beats (data and arrival cycle) and the error flag.
    task automatic settle();
        int n;
        repeat (2) @(negedge clk);
        check("dv_count", obs_d.size(), exp_d.size());
        n = (obs_d.size() < exp_d.size()) ? obs_d.size() : exp_d.size();
        for (int i = 0; i < n; i++) begin
            check("dv_data", obs_d[i], exp_d[i]);
            check("dv_cycle", obs_c[i], exp_c[i]);
        end
        check("bus_error", bus_error, model_err);
        obs_d.delete(); obs_c.delete(); exp_d.delete(); exp_c.delete();
    endtask

    // Read of nbeats beats (rlast on the last); only the first stop_at beats are sent.
    task automatic do_read(input logic [31:0] addr, input logic [4:0] size, input int nbeats,
                           input int ar_delay, input logic [31:0] gap_mask, input int err_beat,
                           input logic [1:0] err_resp, input logic [31:0] dbase, input int stop_at);
        logic [31:0] d;
        req_addr = addr; req_rnw = 1'b1; req_size = size; req_is_amo = 1'b0;
        req_data = $urandom; req_be = 4'hF; req_request = 1'b1;
        #1 check("ack_rd", req_ack, 1);
        @(negedge clk);
        req_request = 1'b0;
        for (int i = 0; i <= ar_delay; i++) begin
            check("arvalid", arvalid, 1);
            check("araddr", araddr, {addr[31:2], 2'b00});
            check("arlen", arlen, {3'b000, size});
            check("ar_fixed", {arsize, arburst, arcache, arprot, arlock, arid},
                  {3'b010, 2'b01, 4'b0011, 3'b000, 1'b0, 6'd0});
            if (i == ar_delay) begin
                arready = 1'b1;
            end else if (i == 0) begin
                req_request = 1'b1;
                #1 check("no_ack_busy", req_ack, 0);
                req_request = 1'b0;
            end
            @(negedge clk);
        end
        arready = 1'b0;
        check("arvalid_drop", arvalid, 0);
        for (int b = 0; b < stop_at; b++) begin
            if (gap_mask[b]) begin
                rvalid = 1'b0;
                @(negedge clk);
            end
            check("rready", rready, 1);
            d = dbase + b;
            rvalid = 1'b1; rdata = d; rlast = (b == nbeats - 1);
            rresp = (b == err_beat) ? err_resp : 2'b00;
            if (rresp != 2'b00) model_err = 1;
            exp_d.push_back(d);
            exp_c.push_back(cyc + 1);
            @(negedge clk);
        end
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        if (stop_at == nbeats && nbeats != int'(size) + 1) model_err = 1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be,
                            input int aw_delay, input int w_delay, input int b_delay,
                            input logic [1:0] resp);
        bit aw_t = 0;
        bit w_t = 0;
        int i = 0;
        req_addr = addr; req_data = data; req_be = be; req_rnw = 1'b0; req_is_amo = 1'b0;
        req_size = 5'($urandom_range(0, 31)); req_request = 1'b1;
        #1 check("ack_wr", req_ack, 1);
        @(negedge clk);
        req_request = 1'b0;
        while (!(aw_t && w_t) && i < 64) begin
            check("awvalid", awvalid, !aw_t);
            check("wvalid", wvalid, !w_t);
            if (!aw_t) begin
                check("awaddr", awaddr, {addr[31:2], 2'b00});
                check("aw_fixed", {awlen, awsize, awburst}, {8'd0, 3'b010, 2'b01});
            end
            if (!w_t) begin
                check("wdata", wdata, data);
                check("wstrb", wstrb, be);
                check("wlast", wlast, 1);
            end
            awready = !aw_t && (i >= aw_delay);
            wready  = !w_t && (i >= w_delay);
            @(negedge clk);
            if (awready) aw_t = 1;
            if (wready) w_t = 1;
            i++;
        end
        awready = 1'b0; wready = 1'b0;
        check("aww_valids_low", {awvalid, wvalid}, 2'b00);
        for (int j = 0; j < b_delay; j++) begin
            check("bready_wait", bready, 1);
            @(negedge clk);
        end
        check("bready", bready, 1);
        bvalid = 1'b1; bresp = resp;
        if (resp != 2'b00) model_err = 1;
        @(negedge clk);
        bvalid = 1'b0; bresp = 2'b00;
        check("bready_drop", bready, 0);
    endtask

    task automatic do_amo(input logic [31:0] addr);
        req_addr = addr; req_is_amo = 1'b1; req_rnw = 1'($urandom_range(0, 1));
        req_amo = 5'($urandom_range(0, 31)); req_request = 1'b1;
        #1 check("ack_amo", req_ack, 1);
        exp_d.push_back(32'h0);
        exp_c.push_back(cyc + 1);
        model_err = 1;
        @(negedge clk);
        req_request = 1'b0; req_is_amo = 1'b0;
        check("amo_no_axi", {arvalid, awvalid, wvalid}, 3'b000);
    endtask

    initial begin
        int kind, size, nb, err_beat;
        rst_n = 1'b0;
        req_addr = '0; req_data = '0; req_rnw = 1'b0; req_be = '0; req_size = '0;
        req_is_amo = 1'b0; req_amo = '0; req_request = 1'b0; inv_ack = 1'b0;
        awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0;
        arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;

        repeat (2) @(negedge clk);
        reset_checks();
        rst_n = 1'b1;
        @(negedge clk);

        do_read(32'h1000_0004, 5'd0, 1, 0, 32'h0, -1, 2'b00, 32'hDEAD_BEEF, 1);
        settle();

        do_read(32'h2000_0010, 5'd3, 4, 2, 32'h4, -1, 2'b00, 32'h0, 4);
        settle();

        // Write runs back to back: each next ack falls one cycle after bvalid.
        do_write(32'h3000_0008, 32'hA5A5_1234, 4'b0011, 3, 0, 0, 2'b00);
        do_write(32'h3000_0008, 32'hA5A5_1234, 4'b0011, 0, 3, 1, 2'b00);
        do_write(32'h3000_0008, 32'hA5A5_1234, 4'b0011, 1, 1, 0, 2'b00);
        settle();

        do_read(32'h4000_0000, 5'd1, 2, 0, 32'h0, 1, 2'b10, 32'h55AA_0000, 2);
        settle();
        do_read(32'h4000_0100, 5'd0, 1, 0, 32'h0, -1, 2'b00, 32'h1111_2222, 1);
        do_write(32'h4000_0200, 32'h1, 4'hF, 0, 0, 0, 2'b00);
        settle();
        do_reset();

        do_write(32'h5000_0000, 32'hCAFE_F00D, 4'hF, 0, 0, 0, 2'b11);
        settle();
        do_reset();

        do_amo(32'h6000_0000);
        settle();
        do_reset();

        do_read(32'h7000_0000, 5'd1, 1, 0, 32'h0, -1, 2'b00, 32'h7777_0000, 1);
        settle();
        do_reset();

        do_read(32'h8000_0000, 5'd3, 4, 0, 32'h0, -1, 2'b00, 32'h8888_0000, 2);
        do_reset();
        settle();
        do_read(32'h8000_0040, 5'd3, 4, 1, 32'h0, -1, 2'b00, 32'h9999_0000, 4);
        settle();

        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 9);
            if (kind < 5) begin
                size = $urandom_range(0, 7);
                nb = size + 1;
                if ($urandom_range(0, 7) == 0) nb = (size > 0 && $urandom_range(0, 1) == 1) ? size : size + 2;
                err_beat = ($urandom_range(0, 9) == 0) ? $urandom_range(0, nb - 1) : -1;
                do_read($urandom, 5'(size), nb, $urandom_range(0, 3), $urandom & $urandom,
                        err_beat, 2'($urandom_range(1, 3)), $urandom, nb);
            end else if (kind < 9) begin
                do_write($urandom, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 2),
                         ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
            end else begin
                do_amo($urandom);
            end
            settle();
            if (model_err && $urandom_range(0, 2) == 0) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
